// File: rtl/yarp_data_mem_resp_if.sv
// Load/store request-response bus between an initiator and yarp_data_mem_resp.
// The initiator holds req_i until it sees the one-cycle ready_o strobe.
interface yarp_data_mem_resp_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic [1:0]  byte_en_i;
  logic        wr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;
  logic        ready_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, byte_en_i, wr_i, wr_data_i,
    input  rd_data_o, ready_o, err_o
  );

  modport slave (
    input  req_i, addr_i, byte_en_i, wr_i, wr_data_i,
    output rd_data_o, ready_o, err_o
  );
endinterface

// File: rtl/yarp_data_mem_resp.sv
// Data memory with an IDLE/WAIT/RESP handshake, byte/halfword/word access and error response.
// Macro YARP_DMEM_ALIGN_CHK_EN: when defined, misaligned halfword/word accesses are errors.
module yarp_data_mem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic                 clk,
  input logic                 reset,
  yarp_data_mem_resp_if.slave bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;

  logic [31:0] r_addr;
  logic [1:0]  r_be;
  logic        r_wr;
  logic [31:0] r_wdata;

  logic        r_ready;
  logic        r_err;
  logic [31:0] r_rd_data;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0] w_s_addr;
  logic [1:0]  w_s_be;
  logic        w_s_wr;
  logic [31:0] w_s_wdata;
  logic        w_oob;
  logic        w_misalign;
  logic        w_err;
  logic [1:0]  w_off;
  logic [3:0]  w_lanes;
  logic [3:0]  w_size_lanes;
  logic [31:0] w_rd_mask;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rd_word;
  logic [31:0] w_load_data;
  logic [31:0] w_wr_word;
  logic        w_enter_resp;
  logic        w_do_write;

  // With WAIT_STATES=0 the response is computed on the capture edge itself, so
  // the access attributes come straight from the bus while IDLE.
  assign w_s_addr  = (r_state == IDLE) ? bus.addr_i    : r_addr;
  assign w_s_be    = (r_state == IDLE) ? bus.byte_en_i : r_be;
  assign w_s_wr    = (r_state == IDLE) ? bus.wr_i      : r_wr;
  assign w_s_wdata = (r_state == IDLE) ? bus.wr_data_i : r_wdata;

  assign w_oob = (w_s_addr[31:2] >= 30'(DEPTH_WORDS));

`ifdef YARP_DMEM_ALIGN_CHK_EN
  assign w_misalign = ((w_s_be == SZ_HALF) && w_s_addr[0]) ||
                      ((w_s_be == SZ_WORD) && (w_s_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = (w_s_be == 2'b10) || w_oob || w_misalign;

  // Offset is taken from the size-aligned address; with alignment checking on,
  // a misaligned access is already an error so the truncation is harmless.
  always_comb begin
    w_off        = 2'b00;
    w_lanes      = 4'b0000;
    w_size_lanes = 4'b0000;
    case (w_s_be)
      SZ_BYTE: begin
        w_off        = w_s_addr[1:0];
        w_lanes      = 4'b0001 << w_s_addr[1:0];
        w_size_lanes = 4'b0001;
      end
      SZ_HALF: begin
        w_off        = {w_s_addr[1], 1'b0};
        w_lanes      = w_s_addr[1] ? 4'b1100 : 4'b0011;
        w_size_lanes = 4'b0011;
      end
      SZ_WORD: begin
        w_off        = 2'b00;
        w_lanes      = 4'b1111;
        w_size_lanes = 4'b1111;
      end
      default: begin
        w_off        = 2'b00;
        w_lanes      = 4'b0000;
        w_size_lanes = 4'b0000;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_mask
      assign w_rd_mask[gi*8 +: 8] = {8{w_size_lanes[gi]}};
    end
  endgenerate

  assign w_idx       = w_s_addr[AW+1:2];
  assign w_rd_word   = r_mem[w_idx];
  assign w_load_data = (w_rd_word >> {w_off, 3'b000}) & w_rd_mask;
  assign w_wr_word   = w_s_wdata << {w_off, 3'b000};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req_i) begin
          w_cnt_next = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) w_state_next = RESP;
          else                  w_state_next = WAIT;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_next = RESP;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_next == RESP);
  assign w_do_write   = (r_state == RESP) && r_wr && !w_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= 32'd0;
      r_addr    <= 32'd0;
      r_be      <= 2'b00;
      r_wr      <= 1'b0;
      r_wdata   <= 32'd0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_ready   <= w_enter_resp;
      r_err     <= w_enter_resp && w_err;
      r_rd_data <= (w_enter_resp && !w_err && !w_s_wr) ? w_load_data : 32'd0;
      if (r_state == IDLE && bus.req_i) begin
        r_addr  <= bus.addr_i;
        r_be    <= bus.byte_en_i;
        r_wr    <= bus.wr_i;
        r_wdata <= bus.wr_data_i;
      end
    end
  end

  // Write lands on the edge that closes RESP; a reset during RESP leaves the
  // state machine out of RESP before that edge, so the store is dropped.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) r_mem[w_idx][i*8 +: 8] <= w_wr_word[i*8 +: 8];
      end
    end
  end

  assign bus.ready_o   = r_ready;
  assign bus.err_o     = r_err;
  assign bus.rd_data_o = r_rd_data;
endmodule

// File: tb/tb_yarp_data_mem_resp.sv
// Directed bench for yarp_data_mem_resp (DEPTH_WORDS=1024, WAIT_STATES=1).
// Expectations for the misaligned store follow macro YARP_DMEM_ALIGN_CHK_EN.
module tb_yarp_data_mem_resp;
  localparam int DEPTH_WORDS = 1024;
  localparam int WAIT_STATES = 1;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b11;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  yarp_data_mem_resp_if bus ();

  yarp_data_mem_resp #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .WAIT_STATES(WAIT_STATES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access, returns the response seen on the ready strobe, the
  // number of edges from capture until ready is seen, and ready one cycle later.
  task automatic do_access(input logic wr, input logic [1:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                           output int lat, output logic strobe_after);
    @(negedge clk);
    bus.req_i     = 1'b1;
    bus.wr_i      = wr;
    bus.byte_en_i = be;
    bus.addr_i    = addr;
    bus.wr_data_i = wdata;
    @(posedge clk);
    lat = 0;
    rd  = 32'hxxxx_xxxx;
    err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        lat = k;
        rd  = bus.rd_data_o;
        err = bus.err_o;
        break;
      end
    end
    bus.req_i = 1'b0;
    bus.wr_i  = 1'b0;
    @(negedge clk);
    strobe_after = bus.ready_o;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req_i     = 1'b0;
    bus.wr_i      = 1'b0;
    bus.byte_en_i = WORD;
    bus.addr_i    = 32'd0;
    bus.wr_data_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.ready_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o);
    end
    vectors++;
    if (bus.err_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_err got=%b exp=0", bus.err_o);
    end
    vectors++;
    if (bus.rd_data_o !== 32'd0) begin
      miscompares++; $display("FAIL reset_rd_data got=%h exp=00000000", bus.rd_data_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic err; int lat; logic sa;
    do_access(1'b1, WORD, 32'h100, 32'hDEADBEEF, rd, err, lat, sa);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL word_store_latency got=%0d exp=2", lat); end
    vectors++;
    if (err !== 1'b0 || rd !== 32'd0) begin
      miscompares++; $display("FAIL word_store_resp got err=%b rd=%h exp err=0 rd=00000000", err, rd);
    end
    vectors++;
    if (sa !== 1'b0) begin miscompares++; $display("FAIL word_store_strobe got=%b exp=0", sa); end
    do_access(1'b0, WORD, 32'h100, 32'h0, rd, err, lat, sa);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL word_load_latency got=%0d exp=2", lat); end
    vectors++;
    if (err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL word_load got err=%b rd=%h exp err=0 rd=deadbeef", err, rd);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic err; int lat; logic sa;
    do_access(1'b1, WORD, 32'h100, 32'h00000000, rd, err, lat, sa);
    do_access(1'b1, BYTE, 32'h101, 32'hFFFFFFAB, rd, err, lat, sa);
    do_access(1'b0, WORD, 32'h100, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== 32'h0000AB00) begin miscompares++; $display("FAIL byte_store_word_load got=%h exp=0000ab00", rd); end
    do_access(1'b0, BYTE, 32'h101, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== 32'h000000AB || err !== 1'b0) begin
      miscompares++; $display("FAIL byte_load got rd=%h err=%b exp rd=000000ab err=0", rd, err);
    end
    do_access(1'b1, HALF, 32'h102, 32'hFFFF1234, rd, err, lat, sa);
    do_access(1'b0, HALF, 32'h102, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== 32'h00001234) begin miscompares++; $display("FAIL half_load got=%h exp=00001234", rd); end
    do_access(1'b0, WORD, 32'h100, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== 32'h1234AB00) begin miscompares++; $display("FAIL half_store_word_load got=%h exp=1234ab00", rd); end
    do_access(1'b0, BYTE, 32'h103, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== 32'h00000012) begin miscompares++; $display("FAIL byte_load_lane3 got=%h exp=00000012", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic err; int lat; logic sa;
    logic exp_err; logic [31:0] exp_word;
`ifdef YARP_DMEM_ALIGN_CHK_EN
    exp_err  = 1'b1;
    exp_word = 32'h11223344;
`else
    exp_err  = 1'b0;
    exp_word = 32'hCAFEF00D;
`endif
    do_access(1'b1, WORD, 32'h100, 32'h11223344, rd, err, lat, sa);
    do_access(1'b1, WORD, 32'h101, 32'hCAFEF00D, rd, err, lat, sa);
    vectors++;
    if (lat !== 2 || err !== exp_err) begin
      miscompares++; $display("FAIL misaligned_store got lat=%0d err=%b exp lat=2 err=%b", lat, err, exp_err);
    end
    do_access(1'b0, WORD, 32'h100, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== exp_word) begin miscompares++; $display("FAIL misaligned_store_effect got=%h exp=%h", rd, exp_word); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat; logic sa;
    do_access(1'b1, WORD, 32'h000, 32'h0BADF00D, rd, err, lat, sa);
    do_access(1'b0, 2'b10, 32'h000, 32'h0, rd, err, lat, sa);
    vectors++;
    if (err !== 1'b1 || rd !== 32'd0) begin
      miscompares++; $display("FAIL illegal_size got err=%b rd=%h exp err=1 rd=00000000", err, rd);
    end
    do_access(1'b0, WORD, 32'(DEPTH_WORDS * 4), 32'h0, rd, err, lat, sa);
    vectors++;
    if (err !== 1'b1 || rd !== 32'd0) begin
      miscompares++; $display("FAIL oob_load got err=%b rd=%h exp err=1 rd=00000000", err, rd);
    end
    do_access(1'b1, WORD, 32'(DEPTH_WORDS * 4), 32'h77777777, rd, err, lat, sa);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL oob_store_err got=%b exp=1", err); end
    do_access(1'b1, 2'b10, 32'h000, 32'h66666666, rd, err, lat, sa);
    do_access(1'b0, WORD, 32'h000, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== 32'h0BADF00D || err !== 1'b0) begin
      miscompares++; $display("FAIL error_store_suppressed got rd=%h err=%b exp rd=0badf00d err=0", rd, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat; logic sa;
    int seen;
    do_access(1'b1, WORD, 32'h108, 32'h00000000, rd, err, lat, sa);
    @(negedge clk);
    bus.req_i = 1'b1; bus.wr_i = 1'b1; bus.byte_en_i = WORD;
    bus.addr_i = 32'h104; bus.wr_data_i = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    // In-flight store must ignore these changes
    bus.addr_i = 32'h108; bus.wr_data_i = 32'hFFFFFFFF; bus.byte_en_i = 2'b10;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      if (bus.ready_o === 1'b1) seen = 1;
      else @(negedge clk);
    end
    vectors++;
    if (seen != 1 || bus.err_o !== 1'b0) begin
      miscompares++; $display("FAIL b2b_store_resp got seen=%0d err=%b exp seen=1 err=0", seen, bus.err_o);
    end
    // Keep req high: next access is a load of the just-stored word
    bus.wr_i = 1'b0; bus.addr_i = 32'h104; bus.byte_en_i = WORD; bus.wr_data_i = 32'h0;
    @(negedge clk);
    vectors++;
    if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap got ready=%b exp=0", bus.ready_o); end
    @(negedge clk);
    bus.req_i = 1'b0;
    vectors++;
    if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_wait_gap got ready=%b exp=0", bus.ready_o); end
    @(negedge clk);
    vectors++;
    if (bus.ready_o !== 1'b1 || bus.rd_data_o !== 32'hA5A5A5A5) begin
      miscompares++; $display("FAIL b2b_load got ready=%b rd=%h exp ready=1 rd=a5a5a5a5", bus.ready_o, bus.rd_data_o);
    end
    do_access(1'b0, WORD, 32'h108, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== 32'h00000000) begin miscompares++; $display("FAIL b2b_inflight_isolation got=%h exp=00000000", rd); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] rd; logic err; int lat; logic sa;
    int seen;
    do_access(1'b1, WORD, 32'h200, 32'h13579BDF, rd, err, lat, sa);
    // Reset while the store sits in WAIT
    @(negedge clk);
    bus.req_i = 1'b1; bus.wr_i = 1'b1; bus.byte_en_i = WORD;
    bus.addr_i = 32'h200; bus.wr_data_i = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.ready_o !== 1'b0 || bus.err_o !== 1'b0 || bus.rd_data_o !== 32'd0) begin
      miscompares++; $display("FAIL reset_in_wait got ready=%b err=%b rd=%h exp 0/0/00000000",
                              bus.ready_o, bus.err_o, bus.rd_data_o);
    end
    bus.req_i = 1'b0; bus.wr_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // Reset while the store sits in RESP, before the write edge
    @(negedge clk);
    bus.req_i = 1'b1; bus.wr_i = 1'b1; bus.byte_en_i = WORD;
    bus.addr_i = 32'h200; bus.wr_data_i = 32'h2468ACE0;
    @(posedge clk);
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) seen = 1;
    end
    vectors++;
    if (seen != 1) begin miscompares++; $display("FAIL reset_resp_reach got seen=%0d exp=1", seen); end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_in_resp got ready=%b exp=0", bus.ready_o); end
    bus.req_i = 1'b0; bus.wr_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_access(1'b0, WORD, 32'h200, 32'h0, rd, err, lat, sa);
    vectors++;
    if (rd !== 32'h13579BDF || err !== 1'b0) begin
      miscompares++; $display("FAIL reset_dropped_store got rd=%h err=%b exp rd=13579bdf err=0", rd, err);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_word();
    test_byte_half();
    test_misalign();
    test_errors();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/yarp_data_mem_resp.md
YARP_DATA_MEM_RESP -- requirements
Module: yarp_data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: storage depth in 32-bit words; the word index is addr_i[log2(DEPTH_WORDS)+1:2].
REQ-002 Parameter WAIT_STATES, default 1, range 0..15: idle cycles inserted between request capture and response.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req_i, input, 1: request valid; held high by the initiator until ready_o is seen.
REQ-006 Port addr_i, input, 32: byte address.
REQ-007 Port byte_en_i, input, 2: access size per mem_access_size_e (BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b11; 2'b10 is illegal).
REQ-008 Port wr_i, input, 1: 1=store, 0=load.
REQ-009 Port wr_data_i, input, 32: store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-010 Port rd_data_o, output, 32: load data, right-justified, unextended; valid only while ready_o=1.
REQ-011 Port ready_o, output, 1: one-cycle response strobe.
REQ-012 Port err_o, output, 1: error qualifier; valid only while ready_o=1.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 IDLE with req_i=1 SHALL capture addr_i, byte_en_i, wr_i and wr_data_i, load the wait counter with WAIT_STATES, and go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-015 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle after the counter reaches 1.
REQ-016 Inputs changing after capture SHALL have no effect on the transaction in flight.
REQ-017 RESP SHALL last exactly one cycle, drive ready_o=1, and return to IDLE.
REQ-018 Request-to-ready latency SHALL be WAIT_STATES+1 cycles from the capture edge.
REQ-019 A req_i still high in the IDLE cycle after RESP SHALL be captured as a new request, giving a throughput of one access per WAIT_STATES+2 cycles.
REQ-020 A store SHALL update only the addressed lanes: BYTE writes lane addr[1:0]; HALF_WORD writes lanes {addr[1],0} and {addr[1],1}; WORD writes all four lanes.
REQ-021 A store SHALL perform its write in the RESP cycle.
REQ-022 A load SHALL read the word in RESP and shift it right by 8*addr[1:0] so the addressed byte or halfword lands at bit 0.
REQ-023 A load SHALL clear the upper bits that do not belong to the access; sign or zero extension stays with the initiator.
REQ-024 A store response SHALL drive rd_data_o=0.
REQ-025 An error condition SHALL be any of: byte_en=2'b10; a word index >= DEPTH_WORDS; a misaligned access (REQ-033).
REQ-026 An error access SHALL assert err_o=1 with ready_o, suppress the write, and drive rd_data_o=0.
REQ-027 Outside RESP, ready_o=0, err_o=0 and rd_data_o=0.
REQ-028 There SHALL be no combinational path from inputs to outputs; all outputs are registered.

Reset
REQ-029 Asserting reset at any time SHALL force IDLE, wait counter=0, ready_o=0, err_o=0 and rd_data_o=0 asynchronously.
REQ-030 A transaction interrupted by reset SHALL be dropped with no write performed, including reset asserted during RESP before the clock edge.
REQ-031 Memory contents SHALL not be reset.
REQ-032 The first capture SHALL occur on the first rising edge with reset low and req_i high.

Configuration
REQ-033 Macro YARP_DMEM_ALIGN_CHK_EN defined: HALF_WORD with addr[0]=1 and WORD with addr[1:0]!=0 SHALL be error accesses per REQ-026.
REQ-034 Macro YARP_DMEM_ALIGN_CHK_EN undefined: misalignment SHALL not be an error; HALF_WORD ignores addr[0] and WORD ignores addr[1:0], with lanes and shift computed from the aligned address; the other error conditions remain.

Verification
REQ-035 WAIT_STATES=1: WORD store 0xDEADBEEF @0x100, then WORD load @0x100 -> ready_o two cycles after each capture; load returns 0xDEADBEEF, err_o=0.
REQ-036 BYTE store 0xAB @0x101 over 0x00000000, then WORD load @0x100 -> 0x0000AB00; BYTE load @0x101 -> 0x000000AB.
REQ-037 HALF_WORD store 0x1234 @0x102, then HALF_WORD load @0x102 -> 0x00001234; the word at 0x100 reads 0x1234xxxx with lanes 0-1 unchanged.
REQ-038 With YARP_DMEM_ALIGN_CHK_EN: WORD store @0x101 -> ready_o=1, err_o=1, word 0x100 unchanged. Without it: the same store writes word 0x100, err_o=0.
REQ-039 byte_en=2'b10, and separately addr=DEPTH_WORDS*4 -> err_o=1, rd_data_o=0; req_i held high through RESP -> the next access is captured the following cycle.
REQ-040 Assert reset in the WAIT state of a WORD store 0x55555555 @0x200 -> outputs 0 immediately; a later load @0x200 returns the prior value.
